// File: rtl/fft_interconnect_pkg.sv
// Shared definitions for the four-lane to serial FFT interconnect.
// Provides the FILL/SEND state encoding and NFFT / quarter-frame size helpers.
package fft_interconnect_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Frame length for a given log2 size.
  function automatic int unsigned calc_nfft(input int unsigned size_buffer);
    return 32'd1 << size_buffer;
  endfunction

  // Samples carried by one lane (a quarter of the frame).
  function automatic int unsigned calc_quarter(input int unsigned size_buffer);
    return calc_nfft(size_buffer) / 32'd4;
  endfunction

endpackage

// File: rtl/interconnect_quarter_buffer.sv
// One lane of the interconnect: a Q-deep I/Q store with fill counter,
// registered ready and an asynchronous read port.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   fill_next_i          controller will be in FILL next cycle
//   clear_i              frame finished, restart fill count
//   valid_i, data_*_i    lane sample input
//   ready_o              lane can accept a sample (registered)
//   full_nxt_c_o         lane will hold Q samples after this edge (comb)
//   rd_idx_i, rd_*_c_o   read address and data (comb)
module interconnect_quarter_buffer
  import fft_interconnect_pkg::*;
#(
  parameter int unsigned SIZE_BUFFER   = 4,
  parameter int unsigned DATA_FFT_SIZE = 16,
  parameter int unsigned IDX_W         = (SIZE_BUFFER > 2) ? SIZE_BUFFER - 2 : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fill_next_i,
  input  logic                     clear_i,
  input  logic                     valid_i,
  input  logic [DATA_FFT_SIZE-1:0] data_i_i,
  input  logic [DATA_FFT_SIZE-1:0] data_q_i,
  output logic                     ready_o,
  output logic                     full_nxt_c_o,
  input  logic [IDX_W-1:0]         rd_idx_i,
  output logic [DATA_FFT_SIZE-1:0] rd_i_c_o,
  output logic [DATA_FFT_SIZE-1:0] rd_q_c_o
);

  localparam int unsigned Q     = calc_quarter(SIZE_BUFFER);
  localparam int unsigned CW    = SIZE_BUFFER - 1;
  localparam int unsigned DEPTH = 32'd1 << IDX_W;

  logic [DATA_FFT_SIZE-1:0] mem_i_q [DEPTH];
  logic [DATA_FFT_SIZE-1:0] mem_q_q [DEPTH];
  logic [CW-1:0]            fill_cnt_q, fill_cnt_d;
  logic                     ready_q, ready_d;
  logic                     wr_en;
  logic [IDX_W-1:0]         wr_idx;

  assign wr_en  = valid_i & ready_q;
  assign wr_idx = IDX_W'(fill_cnt_q);

  // Fill count and next-cycle ready
  always_comb begin
    fill_cnt_d = fill_cnt_q;
    if (clear_i) begin
      fill_cnt_d = '0;
    end else if (wr_en) begin
      fill_cnt_d = fill_cnt_q + CW'(1);
    end
    full_nxt_c_o = (fill_cnt_d == CW'(Q));
    ready_d      = fill_next_i && (fill_cnt_d < CW'(Q));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fill_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      ready_q    <= ready_d;
    end
  end

  // Sample storage, intentionally not reset
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_i_q[wr_idx] <= data_i_i;
      mem_q_q[wr_idx] <= data_q_i;
    end
  end

  // Read with write bypass so the first SEND sample is correct even when it
  // is written on the same edge the frame completes (Q == 1).
  always_comb begin
    rd_i_c_o = mem_i_q[rd_idx_i];
    rd_q_c_o = mem_q_q[rd_idx_i];
    if (wr_en && (wr_idx == rd_idx_i)) begin
      rd_i_c_o = data_i_i;
      rd_q_c_o = data_q_i;
    end
  end

  assign ready_o = ready_q;

endmodule

// File: rtl/interconnect_four_data_to_sfft.sv
// Collects a frame from four parallel lanes (lane k holds samples k*Q..k*Q+Q-1)
// and streams it serially to an FFT with valid/ready handshaking.
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_validk, i_datak_i/q, o_readyk lane k sample input handshake
//   o_fft_valid, o_data_to_fft_i/q  registered serial output
//   i_fft_ready                     FFT accepts the presented sample
//   o_fft_last                      last-sample flag, only with FFT_FRAME_LAST_EN
module interconnect_four_data_to_sfft
  import fft_interconnect_pkg::*;
#(
  parameter int unsigned SIZE_BUFFER   = 4,
  parameter int unsigned DATA_FFT_SIZE = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid0,
  input  logic                     i_valid1,
  input  logic                     i_valid2,
  input  logic                     i_valid3,
  input  logic [DATA_FFT_SIZE-1:0] i_data0_i,
  input  logic [DATA_FFT_SIZE-1:0] i_data1_i,
  input  logic [DATA_FFT_SIZE-1:0] i_data2_i,
  input  logic [DATA_FFT_SIZE-1:0] i_data3_i,
  input  logic [DATA_FFT_SIZE-1:0] i_data0_q,
  input  logic [DATA_FFT_SIZE-1:0] i_data1_q,
  input  logic [DATA_FFT_SIZE-1:0] i_data2_q,
  input  logic [DATA_FFT_SIZE-1:0] i_data3_q,
  output logic                     o_ready0,
  output logic                     o_ready1,
  output logic                     o_ready2,
  output logic                     o_ready3,
  output logic                     o_fft_valid,
  output logic [DATA_FFT_SIZE-1:0] o_data_to_fft_i,
  output logic [DATA_FFT_SIZE-1:0] o_data_to_fft_q,
`ifdef FFT_FRAME_LAST_EN
  output logic                     o_fft_last,
`endif
  input  logic                     i_fft_ready
);

  localparam int unsigned NFFT = calc_nfft(SIZE_BUFFER);
  localparam int unsigned Q    = calc_quarter(SIZE_BUFFER);
  localparam int unsigned SW   = SIZE_BUFFER;
  localparam int unsigned IW   = (SIZE_BUFFER > 2) ? SIZE_BUFFER - 2 : 1;
  localparam int unsigned DW   = DATA_FFT_SIZE;

  state_e         state_q, state_d;
  logic [SW-1:0]  send_cnt_q, send_cnt_d;
  logic           fft_valid_q, fft_valid_d;
  logic [DW-1:0]  out_i_q, out_i_d;
  logic [DW-1:0]  out_q_q, out_q_d;

  logic           xfer;
  logic           clear;
  logic           fill_next;
  logic [1:0]     rd_lane;
  logic [IW-1:0]  rd_idx;

  logic [3:0]     lane_valid;
  logic [3:0]     lane_ready;
  logic [3:0]     lane_full_nxt;
  logic [DW-1:0]  lane_di [4];
  logic [DW-1:0]  lane_dq [4];
  logic [DW-1:0]  lane_rd_i [4];
  logic [DW-1:0]  lane_rd_q [4];

  assign lane_valid = {i_valid3, i_valid2, i_valid1, i_valid0};
  assign lane_di[0] = i_data0_i;
  assign lane_di[1] = i_data1_i;
  assign lane_di[2] = i_data2_i;
  assign lane_di[3] = i_data3_i;
  assign lane_dq[0] = i_data0_q;
  assign lane_dq[1] = i_data1_q;
  assign lane_dq[2] = i_data2_q;
  assign lane_dq[3] = i_data3_q;

  assign xfer  = fft_valid_q & i_fft_ready;
  // Final transfer of the frame restarts all lane fills
  assign clear = (state_q == ST_SEND) && xfer && (send_cnt_q == SW'(NFFT - 1));

  for (genvar k = 0; k < 4; k++) begin : g_lane
    interconnect_quarter_buffer #(
      .SIZE_BUFFER   (SIZE_BUFFER),
      .DATA_FFT_SIZE (DATA_FFT_SIZE),
      .IDX_W         (IW)
    ) u_buf (
      .clk_i        (i_clk),
      .rst_i        (i_reset),
      .fill_next_i  (fill_next),
      .clear_i      (clear),
      .valid_i      (lane_valid[k]),
      .data_i_i     (lane_di[k]),
      .data_q_i     (lane_dq[k]),
      .ready_o      (lane_ready[k]),
      .full_nxt_c_o (lane_full_nxt[k]),
      .rd_idx_i     (rd_idx),
      .rd_i_c_o     (lane_rd_i[k]),
      .rd_q_c_o     (lane_rd_q[k])
    );
  end

  // Next state, send counter and output-valid
  always_comb begin
    state_d     = state_q;
    send_cnt_d  = send_cnt_q;
    fft_valid_d = fft_valid_q;
    case (state_q)
      ST_FILL: begin
        if (&lane_full_nxt) begin
          state_d     = ST_SEND;
          send_cnt_d  = '0;
          fft_valid_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (clear) begin
          state_d     = ST_FILL;
          send_cnt_d  = '0;
          fft_valid_d = 1'b0;
        end else if (xfer) begin
          send_cnt_d = send_cnt_q + SW'(1);
        end
      end
      default: begin
        state_d     = ST_FILL;
        send_cnt_d  = '0;
        fft_valid_d = 1'b0;
      end
    endcase
  end

  assign fill_next = (state_d == ST_FILL);
  // Top two count bits pick the lane, the rest index inside it
  assign rd_lane   = 2'(send_cnt_d >> (SW - 2));
  assign rd_idx    = IW'(send_cnt_d & SW'(Q - 1));

  // Output data: sample at the next send count, zero when idle
  always_comb begin
    out_i_d = '0;
    out_q_d = '0;
    if (fft_valid_d) begin
      out_i_d = lane_rd_i[rd_lane];
      out_q_d = lane_rd_q[rd_lane];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_FILL;
      send_cnt_q  <= '0;
      fft_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
    end else begin
      state_q     <= state_d;
      send_cnt_q  <= send_cnt_d;
      fft_valid_q <= fft_valid_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
    end
  end

`ifdef FFT_FRAME_LAST_EN
  logic last_q, last_d;

  assign last_d = fft_valid_d && (send_cnt_d == SW'(NFFT - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end

  assign o_fft_last = last_q;
`endif

  assign o_ready0        = lane_ready[0];
  assign o_ready1        = lane_ready[1];
  assign o_ready2        = lane_ready[2];
  assign o_ready3        = lane_ready[3];
  assign o_fft_valid     = fft_valid_q;
  assign o_data_to_fft_i = out_i_q;
  assign o_data_to_fft_q = out_q_q;

endmodule

// File: tb/tb_interconnect_four_data_to_sfft.sv
// Bench for interconnect_four_data_to_sfft (SIZE_BUFFER=4: NFFT=16, Q=4).
// Scenario table drives lane fills and FFT-ready patterns; expected frame
// samples go to a scoreboard queue and are compared as the DUT emits them.
module tb_interconnect_four_data_to_sfft;

  localparam int NFFT = 16;
  localparam int Q    = 4;

  logic        clk;
  logic        i_reset;
  logic [3:0]  vld;
  logic [15:0] di [4];
  logic [15:0] dq [4];
  logic        i_fft_ready;
  logic        o_ready0, o_ready1, o_ready2, o_ready3;
  logic        o_fft_valid;
  logic [15:0] o_data_to_fft_i, o_data_to_fft_q;
`ifdef FFT_FRAME_LAST_EN
  logic        o_fft_last;
`endif
  logic [3:0]  rdy;

  assign rdy = {o_ready3, o_ready2, o_ready1, o_ready0};

  interconnect_four_data_to_sfft #(
    .SIZE_BUFFER   (4),
    .DATA_FFT_SIZE (16)
  ) dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_valid0        (vld[0]),
    .i_valid1        (vld[1]),
    .i_valid2        (vld[2]),
    .i_valid3        (vld[3]),
    .i_data0_i       (di[0]),
    .i_data1_i       (di[1]),
    .i_data2_i       (di[2]),
    .i_data3_i       (di[3]),
    .i_data0_q       (dq[0]),
    .i_data1_q       (dq[1]),
    .i_data2_q       (dq[2]),
    .i_data3_q       (dq[3]),
    .o_ready0        (o_ready0),
    .o_ready1        (o_ready1),
    .o_ready2        (o_ready2),
    .o_ready3        (o_ready3),
    .o_fft_valid     (o_fft_valid),
    .o_data_to_fft_i (o_data_to_fft_i),
    .o_data_to_fft_q (o_data_to_fft_q),
`ifdef FFT_FRAME_LAST_EN
    .o_fft_last      (o_fft_last),
`endif
    .i_fft_ready     (i_fft_ready)
  );

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    int          idx;
  } exp_t;

  typedef struct {
    int          fill_mode;   // 0: all lanes together, 1: lanes 3,1,0,2 in turn
    int          gap_pct;     // chance a lane idles in a cycle
    int          ready_mode;  // 0: always ready, 1: pattern 1,0,0
    bit          hold0;       // keep i_valid0 high once lane 0 is full
    logic [15:0] base;
    int          exp_cycles;  // SEND cycles expected for the frame
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] s_i(input logic [15:0] base, input int idx);
    return base + 16'(idx);
  endfunction

  function automatic logic [15:0] s_q(input logic [15:0] base, input int idx);
    return ~(base + 16'(idx));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: compare what the DUT presents against the queue head
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_fft_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_sample: got %0h want none", o_data_to_fft_i);
        end else begin
          check($sformatf("data_i[%0d]", sb[0].idx), 32'(o_data_to_fft_i), 32'(sb[0].i));
          check($sformatf("data_q[%0d]", sb[0].idx), 32'(o_data_to_fft_q), 32'(sb[0].q));
`ifdef FFT_FRAME_LAST_EN
          check($sformatf("last[%0d]", sb[0].idx), 32'(o_fft_last), 32'(sb[0].idx == NFFT - 1));
`endif
          if (i_fft_ready) void'(sb.pop_front());
        end
      end else begin
        check("idle_data_i", 32'(o_data_to_fft_i), 32'h0);
        check("idle_data_q", 32'(o_data_to_fft_q), 32'h0);
`ifdef FFT_FRAME_LAST_EN
        check("idle_last", 32'(o_fft_last), 32'h0);
`endif
      end
    end
  end

  task automatic fill_frame(input int mode, input int gap, input bit hold0, input logic [15:0] base);
    int   n[4];
    bit   acc[4];
    int   order[4];
    int   ptr;
    int   cyc;
    logic [3:0] exp_rdy;
    bit   want;
    order = '{3, 1, 0, 2};
    n = '{0, 0, 0, 0};
    ptr = 0;
    cyc = 0;
    while (!(n[0] == Q && n[1] == Q && n[2] == Q && n[3] == Q) && cyc < 500) begin
      for (int k = 0; k < 4; k++) begin
        want = ((mode == 0) || (ptr < 4 && order[ptr] == k)) && (n[k] < Q) &&
               ($urandom_range(0, 99) >= gap);
        vld[k] = want || (hold0 && k == 0 && n[0] == Q);
        di[k]  = want ? s_i(base, k * Q + n[k]) : 16'hDEAD;
        dq[k]  = want ? s_q(base, k * Q + n[k]) : 16'hBEEF;
        exp_rdy[k] = (n[k] < Q);
      end
      check("fill_ready", 32'(rdy), 32'(exp_rdy));
      check("fill_valid_low", 32'(o_fft_valid), 32'h0);
      for (int k = 0; k < 4; k++) acc[k] = vld[k] && rdy[k];
      tick();
      cyc++;
      for (int k = 0; k < 4; k++) if (acc[k]) n[k]++;
      while (ptr < 4 && n[order[ptr]] == Q) ptr++;
    end
    check("fill_timeout", 32'(cyc >= 500), 32'h0);
    vld = {3'b000, hold0};
    for (int s = 0; s < NFFT; s++) sb.push_back('{s_i(base, s), s_q(base, s), s});
    // SEND must begin exactly one cycle after the last lane write
    check("send_entry", 32'(o_fft_valid), 32'h1);
  endtask

  task automatic send_frame(input int rmode, input bit hold0, input int exp_cycles, input int stop_after);
    int cyc;
    int x;
    cyc = 0;
    x = 0;
    while (o_fft_valid && cyc < 200 && x < stop_after) begin
      i_fft_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (i_fft_ready) x++;
      vld[0] = hold0;
      di[0]  = 16'hDEAD;
      dq[0]  = 16'hBEEF;
      check("send_ready_low", 32'(rdy), 32'h0);
      tick();
      cyc++;
    end
    vld = 4'b0000;
    if (stop_after == NFFT) begin
      check("send_cycles", 32'(cyc), 32'(exp_cycles));
      check("send_xfers", 32'(x), 32'(NFFT));
      check("frame_end_valid", 32'(o_fft_valid), 32'h0);
      check("frame_end_ready", 32'(rdy), 32'hF);
      check("frame_drained", 32'(sb.size()), 32'h0);
    end
  endtask

  initial begin
    vecs[0] = '{0, 0,  0, 1'b0, 16'h0000, 16};
    vecs[1] = '{1, 40, 0, 1'b0, 16'h1000, 16};
    vecs[2] = '{0, 0,  1, 1'b0, 16'h2000, 46};
    vecs[3] = '{1, 30, 0, 1'b1, 16'h3000, 16};
    vecs[4] = '{1, 50, 1, 1'b0, 16'h4000, 46};

    i_reset     = 1'b1;
    vld         = 4'b0000;
    i_fft_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      di[k] = '0;
      dq[k] = '0;
    end
    repeat (3) tick();
    check("rst_valid", 32'(o_fft_valid), 32'h0);
    check("rst_data_i", 32'(o_data_to_fft_i), 32'h0);
    check("rst_data_q", 32'(o_data_to_fft_q), 32'h0);
    check("rst_ready", 32'(rdy), 32'h0);
`ifdef FFT_FRAME_LAST_EN
    check("rst_last", 32'(o_fft_last), 32'h0);
`endif
    i_reset = 1'b0;
    tick();
    check("post_rst_ready", 32'(rdy), 32'hF);
    mon_en = 1'b1;

    for (int v = 0; v < 5; v++) begin
      fill_frame(vecs[v].fill_mode, vecs[v].gap_pct, vecs[v].hold0, vecs[v].base);
      send_frame(vecs[v].ready_mode, vecs[v].hold0, vecs[v].exp_cycles, NFFT);
      i_fft_ready = 1'b0;
    end

    // Reset in the middle of a send, then a clean frame
    fill_frame(0, 0, 1'b0, 16'h5000);
    send_frame(0, 1'b0, NFFT, 8);
    i_fft_ready = 1'b0;
    i_reset     = 1'b1;
    tick();
    sb.delete();
    check("midrst_valid", 32'(o_fft_valid), 32'h0);
    check("midrst_ready", 32'(rdy), 32'h0);
    i_reset = 1'b0;
    tick();
    check("midrst_ready_back", 32'(rdy), 32'hF);
    fill_frame(0, 0, 1'b0, 16'h6000);
    send_frame(0, 1'b0, NFFT, NFFT);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interconnect_four_data_to_sfft.md
INTERCONNECT_FOUR_DATA_TO_SFFT -- requirements
Module: interconnect_four_data_to_sfft

Interface
REQ-001 SHALL have parameter SIZE_BUFFER, default 4, log2(NFFT); legal values are 2 or greater.
REQ-002 SHALL have parameter DATA_FFT_SIZE, default 16, I/Q sample width.
REQ-003 SHALL have port i_clk, input, 1, single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have ports i_valid0..i_valid3, input, 1 each, lane k has a sample present.
REQ-006 SHALL have ports i_data0_i..i_data3_i and i_data0_q..i_data3_q, input, DATA_FFT_SIZE each, lane k I/Q sample.
REQ-007 SHALL have ports o_ready0..o_ready3, output, 1 each, lane k can accept a sample.
REQ-008 SHALL have port o_fft_valid, output, 1, serial FFT sample present.
REQ-009 SHALL have ports o_data_to_fft_i and o_data_to_fft_q, output, DATA_FFT_SIZE each, serial sample to the FFT.
REQ-010 SHALL have port i_fft_ready, input, 1, FFT accepts a sample.

Function
REQ-011 SHALL define NFFT = 1<<SIZE_BUFFER and Q = NFFT/4; lane k carries frame samples k*Q .. k*Q+Q-1, in order.
REQ-012 SHALL transfer a lane sample on any edge where i_validk & o_readyk; the sample is written to quarter buffer k at fill_cntk, and fill_cntk increments.
REQ-013 SHALL hold o_readyk high in FILL while fill_cntk < Q; o_readyk goes low on the edge after the Q-th lane-k write. Lanes fill independently and concurrently.
REQ-014 SHALL use two states. FILL goes to SEND on the first edge where all four lanes are full, including when the last writes happen on the same edge. SEND goes to FILL on the edge that accepts sample NFFT-1.
REQ-015 SHALL drive all o_readyk low in SEND; lane inputs in SEND are ignored.
REQ-016 SHALL assert o_fft_valid in the first SEND cycle, which is one cycle after the buffers become full; o_data_to_fft holds sample 0.
REQ-017 SHALL complete an FFT transfer when o_fft_valid & i_fft_ready; send_cnt (SIZE_BUFFER bits) then increments. The top two bits select the buffer and the low bits give the index.
REQ-018 SHALL hold o_fft_valid and the data stable while i_fft_ready is low.
REQ-019 SHALL present the next sample on the edge after each transfer, with no bubble; continuous i_fft_ready gives NFFT samples in NFFT cycles.
REQ-020 SHALL register o_fft_valid and o_data_to_fft; the data outputs are zero whenever o_fft_valid is low.
REQ-021 SHALL, on the final transfer, deassert o_fft_valid, clear all fill_cnt and send_cnt, and raise all o_readyk on the next edge.

Reset
REQ-022 SHALL, while i_reset is high, force: state FILL, all counters 0, o_fft_valid 0, data outputs 0, o_readyk 0; o_readyk goes high the first cycle after reset.
REQ-023 SHALL discard a partial fill or partial send on reset mid-operation; buffer contents need no reset.

Configuration
REQ-024 SHALL, with FFT_FRAME_LAST_EN defined, add output o_fft_last (1 bit, reset 0), high only while o_fft_valid is high and sample NFFT-1 is presented.
REQ-025 SHALL, without FFT_FRAME_LAST_EN, not have port o_fft_last; all other behaviour is identical.

Structure
REQ-026 SHALL place state encoding (FILL/SEND) and NFFT/Q derivation in shared package fft_interconnect_pkg.
REQ-027 SHALL implement each lane as sub-module interconnect_quarter_buffer (Q-deep I/Q store, fill counter, ready, read port), instantiated four times; the top holds the FSM, send counter and output register.

Verification (SIZE_BUFFER=4, NFFT=16, Q=4)
REQ-028 SHALL cover: all lanes fed k*4+n simultaneously with i_fft_ready=1 -> o_fft_valid 16 consecutive cycles, data 0..15, o_readyk high again afterwards.
REQ-029 SHALL cover: lanes filled sequentially 3,1,0,2 with random valid gaps -> output order still 0..15; SEND entry is one cycle after lane 2's last write.
REQ-030 SHALL cover: i_fft_ready toggling 1,0,0,1... during SEND -> every sample is held while stalled, with no loss or duplication; 16 transfers total.
REQ-031 SHALL cover: i_valid0 held high after lane 0 is full, and during SEND -> extra samples are ignored and the frame is unchanged.
REQ-032 SHALL cover: i_reset pulsed after sample 7 is sent -> o_fft_valid is 0 the next cycle; a new full frame then outputs 0..15 correctly.
REQ-033 SHALL cover: with FFT_FRAME_LAST_EN -> o_fft_last high only with sample 15, including a stall on sample 15.
